// File: rtl/psram_q_pkg.sv
// Shared types and FIFO entry layout for the PSRAM write queue.
package psram_q_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

    localparam int ADDR_W   = 22;
    localparam int DATA_W   = 16;
    localparam int ENTRY_W  = 1 + ADDR_W + DATA_W;
    localparam int DATA_LSB = 0;
    localparam int ADDR_LSB = DATA_W;
    localparam int BYTE_BIT = ADDR_W + DATA_W;

    function automatic logic [ENTRY_W-1:0] pack_entry(logic b, logic [ADDR_W-1:0] a,
                                                      logic [DATA_W-1:0] d);
        return {b, a, d};
    endfunction
endpackage

// File: rtl/psram_q_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count; pushes while
// full and pops while empty are ignored.
module psram_q_fifo #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 39,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic [CW-1:0]      count,
    output logic               full,
    output logic               empty
);
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic               push_ok, pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/psram_write_queue.sv
// Write queue and one-at-a-time sequencer in front of the PSRAM CDC wrapper;
// reads are ordered behind every write queued before them.
module psram_write_queue
    import psram_q_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [21:0] req_addr,
    input  logic [15:0] req_data,
    output logic        req_full,
    output logic        req_overflow,
    input  logic        rd_req,
    input  logic [21:0] rd_addr,
    output logic        rd_busy,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        psram_read,
    output logic        psram_write,
    output logic        psram_byte_write,
    output logic [21:0] psram_addr,
    output logic [15:0] psram_din,
    input  logic [15:0] psram_dout,
    input  logic        psram_busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    state_t             state;
    logic [TW-1:0]      timer;
    logic               rd_pending;
    logic [21:0]        rd_addr_q;
    logic [CW-1:0]      writes_ahead;
    logic               op_is_read, op_byte;
    logic [21:0]        op_addr;
    logic [15:0]        op_data;

    logic               fifo_pop, fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               rd_accept, read_ready, done;

    psram_q_fifo #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) u_fifo (
        .clk   (clk32),
        .reset (reset),
        .push  (req_write),
        .pop   (fifo_pop),
        .din   (pack_entry(req_byte, req_addr, req_data)),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (req_full),
        .empty (fifo_empty)
    );

    assign rd_accept  = rd_req && !rd_busy;
    assign read_ready = rd_pending && (writes_ahead == '0);
    assign fifo_pop   = (state == IDLE) && !read_ready && !fifo_empty;
    assign done       = (state == WAIT_HI && !psram_busy && timer == TW'(BUSY_TIMEOUT)) ||
                        (state == WAIT_LO && !psram_busy);

    always_ff @(posedge clk32) begin
        if (reset) begin
            state            <= WAIT_LO;  // let a pre-reset busy drain first
            timer            <= '0;
            rd_pending       <= 1'b0;
            rd_addr_q        <= '0;
            writes_ahead     <= '0;
            op_is_read       <= 1'b0;
            op_byte          <= 1'b0;
            op_addr          <= '0;
            op_data          <= '0;
            req_overflow     <= 1'b0;
            rd_busy          <= 1'b0;
            rd_valid         <= 1'b0;
            rd_data          <= '0;
            psram_read       <= 1'b0;
            psram_write      <= 1'b0;
            psram_byte_write <= 1'b0;
            psram_addr       <= '0;
            psram_din        <= '0;
        end else begin
            psram_read  <= 1'b0;
            psram_write <= 1'b0;
            rd_valid    <= 1'b0;

            if (req_write && req_full) req_overflow <= 1'b1;

            // A write popped in the accept cycle is already ahead of the read.
            if (rd_accept) begin
                rd_pending   <= 1'b1;
                rd_busy      <= 1'b1;
                rd_addr_q    <= rd_addr;
                writes_ahead <= fifo_count - CW'(fifo_pop);
            end else if (fifo_pop && writes_ahead != '0) begin
                writes_ahead <= writes_ahead - CW'(1);
            end
            if (rd_valid) rd_busy <= 1'b0;

            case (state)
                IDLE: begin
                    if (read_ready) begin
                        op_is_read <= 1'b1;
                        state      <= ISSUE;
                    end else if (!fifo_empty) begin
                        op_is_read <= 1'b0;
                        op_byte    <= fifo_dout[BYTE_BIT];
                        op_addr    <= fifo_dout[ADDR_LSB +: ADDR_W];
                        op_data    <= fifo_dout[DATA_LSB +: DATA_W];
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    psram_read       <= op_is_read;
                    psram_write      <= !op_is_read;
                    psram_byte_write <= !op_is_read && op_byte;
                    psram_addr       <= op_is_read ? rd_addr_q : op_addr;
                    if (!op_is_read) psram_din <= op_data;
                    timer <= '0;
                    state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (psram_busy)                          state <= WAIT_LO;
                    else if (timer == TW'(BUSY_TIMEOUT))     state <= IDLE;
                    else                                     timer <= timer + TW'(1);
                end
                WAIT_LO: begin
                    if (!psram_busy) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (done && op_is_read && rd_pending) begin
                rd_data    <= psram_dout;
                rd_valid   <= 1'b1;
                rd_pending <= 1'b0;
            end
        end
    end
endmodule

// File: doc/psram_write_queue.md
# psram_write_queue

Request queue and sequencer in the clk32 domain, directly upstream of the PSRAM clock-domain-crossing wrapper. Buffers write requests from the video/CPU side in a small FIFO and issues them one at a time as single-cycle read/write strobes. Waits on the wrapper's busy signal between operations and returns read data in order with respect to earlier writes.

## Interface
- DEPTH, 8: FIFO entries; a power of two, at least 2.
- BUSY_TIMEOUT, 15: cycles to wait in WAIT_HI for psram_busy before treating the operation as complete.

Ports:
- clk32  in  1  system clock, the only clock.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- req_write  in  1  enqueue a write this cycle.
- req_byte  in  1  write is a byte write (low byte of req_data).
- req_addr  in  22  write address.
- req_data  in  16  write data.
- req_full  out  1  FIFO full; a push in this cycle is dropped.
- req_overflow  out  1  sticky: at least one push was dropped; cleared only by reset.
- rd_req  in  1  read request; accepted only when rd_busy=0.
- rd_addr  in  22  read address.
- rd_busy  out  1  a read is pending.
- rd_valid  out  1  one-cycle pulse; rd_data valid.
- rd_data  out  16  read result; holds its value until the next rd_valid.
- psram_read, psram_write  out  1  one-cycle strobes to the wrapper.
- psram_byte_write  out  1  byte flag for the current write.
- psram_addr  out  22, psram_din  out  16  registered and held stable until the next issue.
- psram_dout  in  16, psram_busy  in  1  from the wrapper.

## Operation
- FIFO entry is {byte, addr, data}, 39 bits.
- Push when req_write=1 and req_full=0.
- req_full is derived from the registered count. A push while full is dropped and sets req_overflow, even if a pop happens in the same cycle.
- Read accept (rd_req=1 and rd_busy=0):
  - Latch rd_addr.
  - Load writes_ahead with the current FIFO count. A simultaneous push is not counted, because it is ordered after the read.
  - rd_busy=1 from the next cycle until the cycle of rd_valid, inclusive.
- writes_ahead decrements on every pop.
- FSM states:
  - IDLE: if a read is pending and writes_ahead=0, go to ISSUE as a read. Else if the FIFO is not empty, pop and go to ISSUE as a write. Else stay in IDLE.
  - ISSUE: drive the selected strobe high for exactly one cycle with addr/din/byte registered, clear the timer, go to WAIT_HI.
  - WAIT_HI: if psram_busy=1, go to WAIT_LO. Else increment the timer; when it reaches BUSY_TIMEOUT, take the completion path (operation finished inside the CDC).
  - WAIT_LO: wait for psram_busy=0. On completion of a read, capture psram_dout into rd_data, pulse rd_valid, clear the read-pending flag. Then go to IDLE.
- Reads bypass writes enqueued after them; reads never bypass writes enqueued before them.
- Never more than one operation outstanding at the wrapper.

## Timing
- Reset values:
  - psram_read=0, psram_write=0, psram_byte_write=0, psram_addr=0, psram_din=0.
  - rd_valid=0, rd_busy=0, rd_data=0.
  - req_full=0, req_overflow=0.
  - FIFO empty, writes_ahead=0, FSM in WAIT_LO.
  - Starting in WAIT_LO lets a busy left over from before reset drain before anything new is issued.
- Reset mid-operation: the FIFO and any pending read are discarded with no rd_valid. The downstream operation completes on its own.
- Write latency, with an empty FIFO and FSM idle: push on edge N, IDLE pops on N+1, psram_write=1 during cycle N+2.
- Read latency, with an empty FIFO: accept on edge N, psram_read=1 during N+2. rd_valid comes in the cycle after psram_busy is sampled low in WAIT_LO.
- Back-to-back operations: minimum 4 cycles apart (IDLE, ISSUE, WAIT_HI, WAIT_LO).
- Full boundary: count=DEPTH sets req_full in the same cycle. Pointers wrap modulo DEPTH.
- Timer width is clog2(BUSY_TIMEOUT+1); the timer does not wrap.

## Structure
- Package psram_q_pkg holds:
  - state enum {IDLE, ISSUE, WAIT_HI, WAIT_LO};
  - ENTRY_W=39;
  - field offsets for byte/addr/data.
- Sub-module psram_q_fifo: synchronous FIFO (DEPTH, ENTRY_W) with push, pop, count, full, empty and registered pointers. The top level owns the FSM, read tracking and overflow flag.

## Test plan
- Single write: push 0x00D020/0x0006 byte; the stub raises busy 3 cycles → psram_write pulses once at N+2 with addr 0x00D020, din 0x0006, byte=1; the next op waits until busy falls.
- Fill: 9 pushes with DEPTH=8 and psram_busy held 1 → req_full after the 8th; 9th dropped; req_overflow=1; after release, exactly 8 writes in order.
- Read ordering: 3 writes queued, then read of 0x000400, then 2 more writes → strobes in order W,W,W,R,W,W; the stub returns 0xBEEF; rd_valid once with rd_data=0xBEEF.
- Timeout: the stub never asserts busy → op completes after BUSY_TIMEOUT+1 cycles in WAIT_HI; the next op issues.
- Simultaneous push while full with a pop in the same cycle → push dropped, overflow set, count = DEPTH-1 next cycle.
- Reset while in WAIT_LO with busy=1 and a read pending → no rd_valid; no strobe until busy=0; FIFO empty.
